h75_apb_regs: RTL
=================

# h75_apb_regs

APB3 slave that is the software-facing front end of the HUB75 display path. It holds the control and BCM timing registers that drive the HUB75 top level, and converts APB writes into single-cycle framebuffer write strobes with an auto-incrementing address. Timing registers are double-buffered: a new value is applied only at a frame boundary, so the panel never shows a frame with mixed BCM weights.

## Interface
Parameters:
- PPR_RST, 10'd64, reset value of pixels_per_row
- BCM_RST_BASE, 12'd16, BCM plane i resets to BCM_RST_BASE << i (16, 32 … 512)

Ports:
- clk  in  1  50 MHz system/APB clock
- resetn  in  1  synchronous, active-low reset on clk
- psel, penable, pwrite  in  1 each  APB3 control
- paddr  in  8  byte address; bits [1:0] ignored
- pwdata  in  32  write data
- prdata  out  32  read data
- pready  out  1  tied 1 (zero wait states)
- pslverr  out  1  error response for unmapped address
- frame_sync  in  1  from the LED-clock timing generator; asynchronous to clk; high ≥ 3 clk periods per frame
- gen_timing, test_pattern  out  1 each  CTRL bits
- pixels_per_row  out  10  active value
- bcm_count  out  72  six 12-bit active values; plane i is bcm_count[12i+11:12i]
- wr_en  out  1  framebuffer write strobe
- wr_addr  out  15  framebuffer word address
- wr_data  out  16  framebuffer word

## Operation
- Access phase: psel & penable. A write commits on the rising edge that ends the access phase.
- Register map:
  - 0x00 CTRL RW: [0] gen_timing, [1] test_pattern.
  - 0x04 PPR RW: [9:0] staging pixels_per_row.
  - 0x08–0x1C BCM0–5 RW: [11:0] staging counts.
  - 0x20 FB_PTR RW: [14:0] write pointer.
  - 0x24 FB_DATA WO: [15:0]; reads return 0.
  - 0x28 STATUS RO: [0] update_pending, [31:16] frame_cnt.
  - 0x2C STATUS_CLR: write 1 to bit 16 to clear frame_cnt.
- Unmapped address: pslverr=1 during the access phase, writes ignored, prdata=0.
- RW reads return the staging value, not the active value. Unused bits read 0.
- A write to PPR or BCMx updates staging and sets update_pending.
- Commit rule:
  - gen_timing=1: on a synchronised rising edge of frame_sync, if update_pending, copy all staging values to active and clear pending.
  - gen_timing=0: copy to active on the cycle after the write; pending clears on that same cycle.
- FB_DATA write: wr_en=1 for exactly one clk cycle, with wr_addr = FB_PTR before increment and wr_data = pwdata[15:0]. FB_PTR then increments modulo 2^15 (0x7FFF wraps to 0x0000).
- frame_cnt increments on each synchronised frame_sync rising edge and saturates at 0xFFFF.

## Timing
- Reset values:
  - prdata=0, pslverr=0, wr_en=0, wr_addr=0, wr_data=0
  - gen_timing=0, test_pattern=0
  - pixels_per_row=PPR_RST (staging and active)
  - bcm_count at BCM reset values (staging and active)
  - FB_PTR=0, update_pending=0, frame_cnt=0, synchroniser flops=0
- prdata and pslverr are combinational from paddr during the access phase, and 0 otherwise.
- CTRL writes reach gen_timing/test_pattern 1 cycle after the commit edge.
- wr_en, wr_addr and wr_data are registered and valid 1 cycle after the commit edge.
- Back-to-back FB_DATA writes (every 2 clk) produce strobes 2 cycles apart with consecutive addresses.
- frame_sync path: 2-flop synchroniser plus edge detect. The edge is seen 3 clk after frame_sync rises.
- Staging write on the same cycle as a frame edge: the previous staging contents commit, the new value is captured, and pending stays 1. It commits at the next edge.
- Write to FB_PTR on the same edge as an FB_DATA write: not possible over APB (one access at a time).
- gen_timing set 1→0 while pending: commit happens on the next cycle.
- Reset asserted mid-transfer: all state returns to reset values on that edge, and any in-flight wr_en is dropped.

## Structure
- Package h75_pkg holds:
  - register offsets (REG_CTRL … REG_STATUS_CLR)
  - field widths (PPR_W=10, BCM_W=12, BCM_N=6, FB_AW=15, FB_DW=16)
  - reset constants
- Sub-module h75_sync_edge: 2-flop synchroniser with rising-edge pulse output, reset on resetn. It is reused wherever the LED clock domain crosses into clk.

## Test plan
- Reset, then read every register → CTRL=0, PPR=64, BCM0..5 = 16, 32, 64, 128, 256, 512, STATUS=0. All outputs match the reset values.
- Write FB_PTR=0x7FFE, then FB_DATA 0xAAAA, 0x5555, 0x1234 → three wr_en pulses at addresses 0x7FFE, 0x7FFF, 0x0000 with those data values; FB_PTR reads 0x0001.
- CTRL=1, write BCM2=0x100 → bcm_count[35:24] stays 64 and STATUS[0]=1. Pulse frame_sync for 4 clk → 3 clk later the active value is 0x100, STATUS[0]=0, frame_cnt=1.
- CTRL=0, write PPR=128 → pixels_per_row=128 one cycle later with no frame_sync.
- Write BCM0 on the exact cycle of the synchronised frame edge → commits only on the following frame_sync edge.
- Read and write to 0x30 → pslverr=1, prdata=0, no register changes. Assert resetn mid-sequence → all values return to reset.

Source files
------------

// File: rtl/h75_pkg.sv
// Shared constants and types for the HUB75 APB register front end:
// register offsets, field widths, reset defaults and the address decoder.
package h75_pkg;

  // Field widths
  localparam int PPR_W       = 10;
  localparam int BCM_W       = 12;
  localparam int BCM_N       = 6;
  localparam int FB_AW       = 15;
  localparam int FB_DW       = 16;
  localparam int FRAME_CNT_W = 16;

  // Register byte offsets
  localparam logic [7:0] REG_CTRL       = 8'h00;
  localparam logic [7:0] REG_PPR        = 8'h04;
  localparam logic [7:0] REG_BCM0       = 8'h08;
  localparam logic [7:0] REG_BCM5       = 8'h1C;
  localparam logic [7:0] REG_FB_PTR     = 8'h20;
  localparam logic [7:0] REG_FB_DATA    = 8'h24;
  localparam logic [7:0] REG_STATUS     = 8'h28;
  localparam logic [7:0] REG_STATUS_CLR = 8'h2C;

  // Bit in STATUS_CLR write data that clears the frame counter
  localparam int STATUS_CLR_BIT = 16;

  // Reset defaults
  localparam logic [PPR_W-1:0] PPR_RST_DEF      = 10'd64;
  localparam logic [BCM_W-1:0] BCM_RST_BASE_DEF = 12'd16;

  typedef struct packed {
    logic test_pattern;
    logic gen_timing;
  } ctrl_t;

  typedef logic [BCM_N-1:0][BCM_W-1:0] bcm_arr_t;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_PPR,
    SEL_BCM,
    SEL_FB_PTR,
    SEL_FB_DATA,
    SEL_STATUS,
    SEL_STATUS_CLR,
    SEL_NONE
  } reg_sel_e;

  // BCM plane i resets to base << i, giving binary-weighted bit planes.
  function automatic bcm_arr_t bcm_rst_vals(input logic [BCM_W-1:0] base);
    bcm_arr_t v;
    for (int i = 0; i < BCM_N; i++) begin
      v[i] = base << i;
    end
    return v;
  endfunction

  // Map a word index (paddr[7:2]) to the register it selects.
  function automatic reg_sel_e decode_word(input logic [5:0] widx);
    if (widx == REG_CTRL[7:2])            return SEL_CTRL;
    else if (widx == REG_PPR[7:2])        return SEL_PPR;
    else if (widx >= REG_BCM0[7:2] &&
             widx <= REG_BCM5[7:2])       return SEL_BCM;
    else if (widx == REG_FB_PTR[7:2])     return SEL_FB_PTR;
    else if (widx == REG_FB_DATA[7:2])    return SEL_FB_DATA;
    else if (widx == REG_STATUS[7:2])     return SEL_STATUS;
    else if (widx == REG_STATUS_CLR[7:2]) return SEL_STATUS_CLR;
    else                                  return SEL_NONE;
  endfunction

endpackage

// File: rtl/h75_sync_edge.sv
// Two-flop synchroniser for a level crossing into the clk domain, followed by
// a rising-edge detector. The pulse is one clk wide and the action it
// triggers lands three clk edges after the asynchronous input rises.
module h75_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic async_in,
  output logic rise
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  // Shift the input through the synchroniser and remember the last level.
  always_comb begin
    sync_d = {sync_q[0], async_in};
    prev_d = sync_q[1];
  end

  // Synchronous active-low reset; all flops clear to 0.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, which is what makes the shift chain work.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/h75_apb_regs.sv
// APB3 register front end of the HUB75 display path. Holds CTRL and the
// double-buffered timing registers (pixels per row, six BCM counts), turns
// FB_DATA writes into one-cycle framebuffer strobes with an auto-incrementing
// pointer, and counts frames. Staged timing values reach the panel only at a
// frame boundary while the timing generator runs, or on the next cycle when
// it is stopped.
module h75_apb_regs
  import h75_pkg::*;
#(
  parameter logic [PPR_W-1:0] PPR_RST      = PPR_RST_DEF,
  parameter logic [BCM_W-1:0] BCM_RST_BASE = BCM_RST_BASE_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [7:0]             paddr,
  input  logic [31:0]            pwdata,
  output logic [31:0]            prdata,
  output logic                   pready,
  output logic                   pslverr,
  input  logic                   frame_sync,
  output logic                   gen_timing,
  output logic                   test_pattern,
  output logic [PPR_W-1:0]       pixels_per_row,
  output logic [BCM_N*BCM_W-1:0] bcm_count,
  output logic                   wr_en,
  output logic [FB_AW-1:0]       wr_addr,
  output logic [FB_DW-1:0]       wr_data
);

  localparam bcm_arr_t BCM_RST = bcm_rst_vals(BCM_RST_BASE);

  // Register state
  ctrl_t                  ctrl_q,      ctrl_d;
  logic [PPR_W-1:0]       ppr_stg_q,   ppr_stg_d;
  logic [PPR_W-1:0]       ppr_act_q,   ppr_act_d;
  bcm_arr_t               bcm_stg_q,   bcm_stg_d;
  bcm_arr_t               bcm_act_q,   bcm_act_d;
  logic                   pending_q,   pending_d;
  logic [FB_AW-1:0]       fb_ptr_q,    fb_ptr_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   wr_en_q,     wr_en_d;
  logic [FB_AW-1:0]       wr_addr_q,   wr_addr_d;
  logic [FB_DW-1:0]       wr_data_q,   wr_data_d;

  // Access decode
  logic     access;
  logic     apb_wr;
  reg_sel_e reg_sel;
  logic [5:0] bcm_off;
  logic [2:0] bcm_idx;
  logic     frame_rise;
  logic     staging_wr;
  logic     commit;

  assign access  = psel & penable;
  assign apb_wr  = access & pwrite;
  assign reg_sel = decode_word(paddr[7:2]);
  assign bcm_off = paddr[7:2] - REG_BCM0[7:2];
  assign bcm_idx = bcm_off[2:0];

  h75_sync_edge u_frame_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (frame_sync),
    .rise     (frame_rise)
  );

  // Staged timing moves to active while the generator runs only on a frame
  // edge; with the generator stopped it moves on the cycle after the write.
  assign commit = pending_q & (~ctrl_q.gen_timing | frame_rise);

  // Next-state for all registers: APB writes, commit, pointer and frame count.
  // NOTE: every _d gets a default at the top so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    ctrl_d      = ctrl_q;
    ppr_stg_d   = ppr_stg_q;
    ppr_act_d   = ppr_act_q;
    bcm_stg_d   = bcm_stg_q;
    bcm_act_d   = bcm_act_q;
    fb_ptr_d    = fb_ptr_q;
    frame_cnt_d = frame_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    staging_wr  = 1'b0;

    // Commit copies the pre-edge staging values, so a staging write on the
    // same edge is kept for the next commit rather than lost.
    if (commit) begin
      ppr_act_d = ppr_stg_q;
      bcm_act_d = bcm_stg_q;
    end

    if (apb_wr) begin
      unique case (reg_sel)
        SEL_CTRL: begin
          ctrl_d.gen_timing   = pwdata[0];
          ctrl_d.test_pattern = pwdata[1];
        end
        SEL_PPR: begin
          ppr_stg_d  = pwdata[PPR_W-1:0];
          staging_wr = 1'b1;
        end
        SEL_BCM: begin
          for (int i = 0; i < BCM_N; i++) begin
            if (bcm_idx == 3'(i)) bcm_stg_d[i] = pwdata[BCM_W-1:0];
          end
          staging_wr = 1'b1;
        end
        SEL_FB_PTR: begin
          fb_ptr_d = pwdata[FB_AW-1:0];
        end
        SEL_FB_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = fb_ptr_q;
          wr_data_d = pwdata[FB_DW-1:0];
          fb_ptr_d  = fb_ptr_q + 1'b1;
        end
        default: ;
      endcase
    end

    pending_d = staging_wr ? 1'b1 : (commit ? 1'b0 : pending_q);

    // Saturating frame counter; a software clear wins over a coincident edge.
    if (apb_wr && reg_sel == SEL_STATUS_CLR && pwdata[STATUS_CLR_BIT]) begin
      frame_cnt_d = '0;
    end else if (frame_rise && frame_cnt_q != '1) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_q      <= '0;
      ppr_stg_q   <= PPR_RST;
      ppr_act_q   <= PPR_RST;
      bcm_stg_q   <= BCM_RST;
      bcm_act_q   <= BCM_RST;
      pending_q   <= 1'b0;
      fb_ptr_q    <= '0;
      frame_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      ppr_stg_q   <= ppr_stg_d;
      ppr_act_q   <= ppr_act_d;
      bcm_stg_q   <= bcm_stg_d;
      bcm_act_q   <= bcm_act_d;
      pending_q   <= pending_d;
      fb_ptr_q    <= fb_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Read mux: staging values for RW registers, zero outside the access phase.
  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (access) begin
      unique case (reg_sel)
        SEL_CTRL:   prdata = {30'd0, ctrl_q.test_pattern, ctrl_q.gen_timing};
        SEL_PPR:    prdata = 32'(ppr_stg_q);
        SEL_BCM: begin
          for (int i = 0; i < BCM_N; i++) begin
            if (bcm_idx == 3'(i)) prdata = 32'(bcm_stg_q[i]);
          end
        end
        SEL_FB_PTR: prdata = 32'(fb_ptr_q);
        SEL_STATUS: prdata = {frame_cnt_q, 15'd0, pending_q};
        SEL_NONE:   pslverr = 1'b1;
        default:    prdata = '0;
      endcase
    end
  end

  assign pready         = 1'b1;
  assign gen_timing     = ctrl_q.gen_timing;
  assign test_pattern   = ctrl_q.test_pattern;
  assign pixels_per_row = ppr_act_q;
  assign bcm_count      = bcm_act_q;
  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;

  // Address byte lanes, high write-data bits and the upper BCM offset bits
  // carry no information for this block.
  logic unused_bits;
  assign unused_bits = ^{paddr[1:0], pwdata[31:17], bcm_off[5:3]};

endmodule
